// File: rtl/trap_sequencer_pkg.sv
// Shared types, CSR addresses and mstatus field positions for trap_sequencer.
// XLEN/ALEN default to 32 unless the build defines them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

package trap_sequencer_pkg;

   localparam int unsigned XLEN    = `XLEN;
   localparam int unsigned ALEN    = `ALEN;
   localparam int unsigned CAUSE_W = 4;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int unsigned MSTATUS_MIE    = 3;
   localparam int unsigned MSTATUS_MPIE   = 7;
   localparam int unsigned MSTATUS_MPP_LO = 11;
   localparam int unsigned MSTATUS_MPP_HI = 12;

   // Saved PCs are word aligned.
   localparam logic [ALEN-1:0] PC_ALIGN_MASK = ~ALEN'(3);

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_level_e;

   typedef enum logic [3:0] {
      CAUSE_INSTR_MISALIGN = 4'd0,
      CAUSE_INSTR_FAULT    = 4'd1,
      CAUSE_ILLEGAL_INSTR  = 4'd2,
      CAUSE_BREAKPOINT     = 4'd3,
      CAUSE_LOAD_MISALIGN  = 4'd4,
      CAUSE_LOAD_FAULT     = 4'd5,
      CAUSE_STORE_MISALIGN = 4'd6,
      CAUSE_STORE_FAULT    = 4'd7,
      CAUSE_ECALL_U        = 4'd8,
      CAUSE_ECALL_M        = 4'd11
   } trap_cause_e;

   localparam logic [3:0] IRQ_M_SOFT  = 4'd3;
   localparam logic [3:0] IRQ_M_TIMER = 4'd7;
   localparam logic [3:0] IRQ_M_EXT   = 4'd11;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WR_MEPC    = 3'd1,
      WR_MCAUSE  = 3'd2,
      WR_MSTATUS = 3'd3,
      REDIRECT   = 3'd4
   } trap_state_e;

endpackage

// File: rtl/trap_target_calc.sv
// Redirect target for traps and xRET. TRAP_SEQUENCER_VECTORED_EN enables
// vectored interrupt targets when mtvec mode is 1.
module trap_target_calc
   import trap_sequencer_pkg::*;
#(
   parameter logic [ALEN-1:0] MTVEC_RESET = '0
) (
   input  logic [ALEN-1:0]    mtvec,
   input  logic [ALEN-1:0]    mepc,
   input  logic               is_xret,
   input  logic               is_irq,
   input  logic [CAUSE_W-1:0] cause,
   output logic [ALEN-1:0]    target_c
);

   logic [ALEN-1:0] base_c;
   assign base_c = {mtvec[ALEN-1:2], 2'b00};

`ifdef TRAP_SEQUENCER_VECTORED_EN
   logic vectored_c;
   logic unused_c;
   assign vectored_c = (mtvec[1:0] == 2'b01) && is_irq;
   assign unused_c   = ^MTVEC_RESET;

   always_comb begin
      if (is_xret) begin
         target_c = mepc;
      end else if (vectored_c) begin
         target_c = base_c + (ALEN'(cause) << 2);
      end else begin
         target_c = base_c;
      end
   end
`else
   logic unused_c;
   assign unused_c = ^{is_irq, cause};

   // An unprogrammed mtvec falls back to the build-time trap vector.
   always_comb begin
      if (is_xret) begin
         target_c = mepc;
      end else if (mtvec == '0) begin
         target_c = MTVEC_RESET;
      end else begin
         target_c = base_c;
      end
   end
`endif

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/xRET sequencer: writes mepc/mcause/mstatus over a CSR
// handshake, then redirects fetch. TRAP_SEQUENCER_VECTORED_EN selects vectored irqs.
module trap_sequencer
   import trap_sequencer_pkg::*;
#(
   parameter logic [ALEN-1:0] MTVEC_RESET = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              exc_valid,
   input  logic [3:0]        exc_cause,
   input  logic [`ALEN-1:0]  exc_pc,
   input  logic              xret_valid,
   input  logic              irq_pending,
   input  logic [3:0]        irq_cause,
   input  logic [`ALEN-1:0]  irq_pc,
   input  logic              wfi_blocked,
   input  logic [`XLEN-1:0]  mstatus,
   input  logic [`ALEN-1:0]  mepc,
   input  logic [`ALEN-1:0]  mtvec,
   output logic              csr_wr_valid,
   output logic [11:0]       csr_wr_addr,
   output logic [`XLEN-1:0]  csr_wr_data,
   input  logic              csr_wr_ready,
   output logic [1:0]        privilege_mode,
   output logic              redirect_valid,
   output logic [`ALEN-1:0]  redirect_target,
   output logic              flush,
   output logic              trap_busy
);

   trap_state_e         state_q, state_d;
   logic                xret_q, xret_d;
   logic                intr_q, intr_d;
   logic [CAUSE_W-1:0]  cause_q, cause_d;
   logic [ALEN-1:0]     pc_q, pc_d;
   logic [XLEN-1:0]     mstatus_q, mstatus_d;
   logic [1:0]          priv_q, priv_d;
   logic                wr_valid_q, wr_valid_d;
   logic [11:0]         wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]     wr_data_q, wr_data_d;
   logic                redir_q, redir_d;
   logic [ALEN-1:0]     target_q, target_d;
   logic [ALEN-1:0]     target_c;
   logic [XLEN-1:0]     mstatus_new_c;
   logic                irq_take_c;
   logic                accept_c;
   logic                unused_c;

   // wfi_blocked only matters upstream (irq_pc already carries the resume PC).
   assign unused_c   = wfi_blocked;
   assign irq_take_c = irq_pending && (mstatus[MSTATUS_MIE] || (priv_q != PRIV_M));

   trap_target_calc #(
      .MTVEC_RESET (MTVEC_RESET)
   ) u_target (
      .mtvec    (mtvec),
      .mepc     (mepc),
      .is_xret  (xret_q),
      .is_irq   (intr_q),
      .cause    (cause_q),
      .target_c (target_c)
   );

   always_comb begin
      state_d    = state_q;
      xret_d     = xret_q;
      intr_d     = intr_q;
      cause_d    = cause_q;
      pc_d       = pc_q;
      mstatus_d  = mstatus_q;
      priv_d     = priv_q;
      accept_c   = 1'b0;
      wr_valid_d = 1'b0;
      wr_addr_d  = '0;
      wr_data_d  = '0;
      redir_d    = 1'b0;
      target_d   = target_q;

      unique case (state_q)
         IDLE: begin
            if (exc_valid) begin
               accept_c  = 1'b1;
               xret_d    = 1'b0;
               intr_d    = 1'b0;
               cause_d   = exc_cause;
               pc_d      = exc_pc & PC_ALIGN_MASK;
               mstatus_d = mstatus;
               state_d   = WR_MEPC;
            end else if (xret_valid) begin
               accept_c  = 1'b1;
               xret_d    = 1'b1;
               intr_d    = 1'b0;
               mstatus_d = mstatus;
               state_d   = WR_MSTATUS;
            end else if (irq_take_c) begin
               accept_c  = 1'b1;
               xret_d    = 1'b0;
               intr_d    = 1'b1;
               cause_d   = irq_cause;
               pc_d      = irq_pc & PC_ALIGN_MASK;
               mstatus_d = mstatus;
               state_d   = WR_MEPC;
            end
         end
         WR_MEPC:    if (csr_wr_ready) state_d = WR_MCAUSE;
         WR_MCAUSE:  if (csr_wr_ready) state_d = WR_MSTATUS;
         WR_MSTATUS: if (csr_wr_ready) state_d = REDIRECT;
         REDIRECT:   state_d = IDLE;
         default:    state_d = IDLE;
      endcase

      // mstatus image written on trap entry or xRET
      mstatus_new_c = mstatus_d;
      if (xret_d) begin
         mstatus_new_c[MSTATUS_MIE]                    = mstatus_d[MSTATUS_MPIE];
         mstatus_new_c[MSTATUS_MPIE]                   = 1'b1;
         mstatus_new_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = PRIV_U;
      end else begin
         mstatus_new_c[MSTATUS_MPIE]                   = mstatus_d[MSTATUS_MIE];
         mstatus_new_c[MSTATUS_MIE]                    = 1'b0;
         mstatus_new_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = priv_q;
      end

      // Outputs are registered from the state being entered.
      unique case (state_d)
         WR_MEPC: begin
            wr_valid_d = 1'b1;
            wr_addr_d  = CSR_MEPC;
            wr_data_d  = XLEN'(pc_d);
         end
         WR_MCAUSE: begin
            wr_valid_d = 1'b1;
            wr_addr_d  = CSR_MCAUSE;
            wr_data_d  = {intr_d, {(XLEN-1-CAUSE_W){1'b0}}, cause_d};
         end
         WR_MSTATUS: begin
            wr_valid_d = 1'b1;
            wr_addr_d  = CSR_MSTATUS;
            wr_data_d  = mstatus_new_c;
         end
         REDIRECT: begin
            redir_d  = 1'b1;
            target_d = target_c;
            priv_d   = xret_q ? mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO] : PRIV_M;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         xret_q     <= 1'b0;
         intr_q     <= 1'b0;
         cause_q    <= '0;
         pc_q       <= '0;
         mstatus_q  <= '0;
         priv_q     <= PRIV_M;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         redir_q    <= 1'b0;
         target_q   <= '0;
      end else begin
         state_q    <= state_d;
         xret_q     <= xret_d;
         intr_q     <= intr_d;
         cause_q    <= cause_d;
         pc_q       <= pc_d;
         mstatus_q  <= mstatus_d;
         priv_q     <= priv_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         redir_q    <= redir_d;
         target_q   <= target_d;
      end
   end

   assign csr_wr_valid    = wr_valid_q;
   assign csr_wr_addr     = wr_addr_q;
   assign csr_wr_data     = wr_data_q;
   assign privilege_mode  = priv_q;
   assign redirect_valid  = redir_q;
   assign flush           = redir_q;
   assign redirect_target = target_q;
   assign trap_busy       = (state_q != IDLE) || accept_c;

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 0, meaning trap base address used when the vectored feature is compiled out and mtvec reads 0.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port exc_valid, input, 1, system/exec unit raises a synchronous exception this cycle.
REQ-005 SHALL have port exc_cause, input, 4, exception cause code.
REQ-006 SHALL have port exc_pc, input, `ALEN, PC of the excepting instruction.
REQ-007 SHALL have port xret_valid, input, 1, a legal MRET retires this cycle.
REQ-008 SHALL have port irq_pending, input, 1, level interrupt request.
REQ-009 SHALL have port irq_cause, input, 4, interrupt cause code.
REQ-010 SHALL have port irq_pc, input, `ALEN, resume PC for an interrupt (next instruction; WFI PC+4 when wfi_blocked).
REQ-011 SHALL have port wfi_blocked, input, 1, core is stalled on WFI.
REQ-012 SHALL have ports mstatus (input, `XLEN), mepc (input, `ALEN) and mtvec (input, `ALEN), the current CSR values.
REQ-013 SHALL have ports csr_wr_valid (output, 1), csr_wr_addr (output, 12), csr_wr_data (output, `XLEN) and csr_wr_ready (input, 1), forming the CSR write handshake.
REQ-014 SHALL have ports privilege_mode (output, 2), redirect_valid (output, 1), redirect_target (output, `ALEN), flush (output, 1) and trap_busy (output, 1).

Function
REQ-015 SHALL implement FSM states IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS and REDIRECT.
REQ-016 In IDLE, SHALL apply priority exc_valid > xret_valid > interrupt; an interrupt is taken when irq_pending && (mstatus.MIE || privilege_mode != MACHINE).
REQ-017 A taken exception or interrupt SHALL sequence IDLE->WR_MEPC->WR_MCAUSE->WR_MSTATUS->REDIRECT->IDLE; xRET SHALL sequence IDLE->WR_MSTATUS->REDIRECT->IDLE.
REQ-018 Each WR state SHALL hold csr_wr_valid, csr_wr_addr and csr_wr_data stable until csr_wr_ready=1, then advance on the next edge; the best-case trap is 5 cycles.
REQ-019 WR_MEPC data SHALL be the captured PC with bits [1:0] forced to 0; WR_MCAUSE data SHALL be {interrupt bit at XLEN-1, zeros, cause[3:0]}.
REQ-020 Trap mstatus write: MPIE<=MIE, MIE<=0, MPP<=privilege_mode; privilege_mode<=MACHINE when entering REDIRECT.
REQ-021 xRET mstatus write: MIE<=MPIE, MPIE<=1, MPP<=USER; privilege_mode<=old MPP when entering REDIRECT.
REQ-022 REDIRECT SHALL assert redirect_valid and flush for exactly 1 cycle, with target mtvec base for traps and mepc for xRET.
REQ-023 Cause, PC and kind SHALL be captured on leaving IDLE; all event inputs are ignored while not in IDLE.
REQ-024 trap_busy SHALL be 1 in every state except IDLE, and SHALL also be 1 in the IDLE cycle that accepts an event.
REQ-025 An interrupt while wfi_blocked SHALL be taken regardless of mstatus.MIE for wakeup purposes only when the enable condition holds; otherwise it is not taken and wfi_blocked persists.

Reset
REQ-026 When rst=0, SHALL asynchronously force: state IDLE, privilege_mode MACHINE (2'b11), csr_wr_valid 0, redirect_valid 0, flush 0, trap_busy 0; data outputs are don't-care.
REQ-027 Reset asserted mid-sequence SHALL abandon the sequence with no further writes; the first cycle after release is IDLE.

Configuration
REQ-028 With macro TRAP_SEQUENCER_VECTORED_EN defined and mtvec[1:0]==1, an interrupt target SHALL be {mtvec[ALEN-1:2],2'b0}+4*cause; exceptions always target the base.
REQ-029 Without TRAP_SEQUENCER_VECTORED_EN, all traps SHALL target the base, or MTVEC_RESET when mtvec==0.

Structure
REQ-030 The state enum, the CSR address constants (MEPC 12'h341, MCAUSE 12'h342, MSTATUS 12'h300) and the mstatus bit indices SHALL live in the shared package alongside priv_levels and trap_causes.
REQ-031 SHALL be a single module; an optional sub-module trap_target_calc computes redirect_target.

Verification
REQ-032 Test: exc_valid, cause 2, exc_pc 0x1002, mtvec 0x100, priv MACHINE, ready tied 1 -> writes mepc 0x1000, then mcause 2, then mstatus with MIE=0; redirect to 0x100 four cycles after accept.
REQ-033 Test: xret_valid with mstatus MPP=USER, MPIE=1, mepc 0x2000 -> write mstatus MIE=1, MPP=0; redirect to 0x2000; privilege_mode becomes 0.
REQ-034 Test: exc_valid and irq_pending asserted in the same cycle -> exception taken; the interrupt is taken after return to IDLE.
REQ-035 Test: csr_wr_ready held 0 for 3 cycles in WR_MCAUSE -> outputs stay stable and the sequence completes afterwards.
REQ-036 Test: VECTORED_EN defined, mtvec 0x101, irq cause 7 -> target 0x11C.
REQ-037 Test: rst pulsed during WR_MSTATUS -> csr_wr_valid drops immediately and privilege_mode reads MACHINE.
